dsp_mem_arbiter: RTL and testbench

Shares the single-port synchronous display RAM (character + attribute cells, 80x30 text grid) between the display refresh path and the CPU bus. The refresh fetch logic issues one read per text column, paced by the pixel timing generator. The CPU bus uses a stb/ack handshake. Display reads always win; the CPU gets every other cycle, so it is never starved and refresh is never delayed.

---
 rtl/dsp_mem_arbiter_pkg.sv | 13 +
 rtl/dsp_mem_arbiter_if.sv | 37 +++
 rtl/dsp_mem_arbiter.sv | 84 ++++++++
 tb/tb_dsp_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mem_arbiter_pkg.sv
// Shared widths and CPU-side FSM encodings for the display RAM arbiter.
package dsp_mem_arbiter_pkg;

  localparam int ARB_ADDR_WIDTH = 12;
  localparam int ARB_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    CPU_IDLE    = 2'd0,
    CPU_RD_WAIT = 2'd1,
    CPU_DONE    = 2'd2
  } cpu_state_t;

endpackage

// File: rtl/dsp_mem_arbiter_if.sv
// Display-fetch, CPU-bus and RAM-side signals of the display RAM arbiter.
interface dsp_mem_arbiter_if
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
);

  logic                  disp_req;
  logic [ADDR_WIDTH-1:0] disp_addr;
  logic [DATA_WIDTH-1:0] disp_data;
  logic                  disp_valid;

  logic                  cpu_stb;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic [DATA_WIDTH-1:0] cpu_dout;
  logic                  cpu_ack;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  disp_req, disp_addr, cpu_stb, cpu_we, cpu_addr, cpu_din, mem_dout,
    output disp_data, disp_valid, cpu_dout, cpu_ack, mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output disp_req, disp_addr, cpu_stb, cpu_we, cpu_addr, cpu_din, mem_dout,
    input  disp_data, disp_valid, cpu_dout, cpu_ack, mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/dsp_mem_arbiter.sv
// Single-port display RAM arbiter: display reads win, CPU uses the gaps.
// Display latency is fixed at 2 cycles; CPU ack is decoded from the DONE state.
//
// state       | meaning
// CPU_IDLE    | waiting for cpu_stb; issue when display is not requesting
// CPU_RD_WAIT | CPU read in flight, capture mem_dout this cycle
// CPU_DONE    | cpu_ack high, no new issue
module dsp_mem_arbiter
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
  input logic              clk,
  input logic              reset,
  dsp_mem_arbiter_if.slave bus
);

  cpu_state_t            state_q;
  cpu_state_t            state_d;
  logic                  cpu_grant;
  logic                  disp_rd1;
  logic                  disp_valid_q;
  logic [DATA_WIDTH-1:0] disp_data_q;
  logic [DATA_WIDTH-1:0] cpu_dout_q;
  logic [ADDR_WIDTH-1:0] issue_addr;

  assign cpu_grant = (state_q == CPU_IDLE) && bus.cpu_stb && !bus.disp_req;

  always_ff @(posedge clk) begin
    if (reset) state_q <= CPU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_IDLE:    if (cpu_grant) state_d = bus.cpu_we ? CPU_DONE : CPU_RD_WAIT;
      CPU_RD_WAIT: state_d = CPU_DONE;
      CPU_DONE:    state_d = CPU_IDLE;
      default:     state_d = CPU_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    issue_addr  = bus.disp_addr;
    if (bus.disp_req) begin
      bus.mem_en = 1'b1;
    end else if (cpu_grant) begin
      bus.mem_en = 1'b1;
      bus.mem_we = bus.cpu_we;
      issue_addr = bus.cpu_addr;
    end
    bus.mem_addr = issue_addr;
    bus.mem_din  = bus.cpu_din;
    bus.cpu_ack  = (state_q == CPU_DONE);
  end

  // Separate in-flight tags keep a CPU read and a following display read apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_rd1     <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      cpu_dout_q   <= '0;
    end else begin
      disp_rd1     <= bus.disp_req;
      disp_valid_q <= disp_rd1;
      if (disp_rd1)                disp_data_q <= bus.mem_dout;
      if (state_q == CPU_RD_WAIT)  cpu_dout_q  <= bus.mem_dout;
    end
  end

  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.cpu_dout   = cpu_dout_q;

  a_disp_spacing: assert property (@(posedge clk) disable iff (reset)
                                   bus.disp_req |=> !bus.disp_req)
    else $error("disp_req asserted in consecutive cycles");

endmodule

// File: tb/tb_dsp_mem_arbiter.sv
// Scoreboard bench for dsp_mem_arbiter with a behavioural single-port RAM.
module tb_dsp_mem_arbiter;
  import dsp_mem_arbiter_pkg::*;

  localparam int AW = ARB_ADDR_WIDTH;
  localparam int DW = ARB_DATA_WIDTH;

  typedef struct { logic [DW-1:0] data; int due; } disp_exp_t;
  typedef struct { logic we; logic [DW-1:0] data; int start; int lat; } cpu_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [DW-1:0] ram     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] ram_q = '0;

  disp_exp_t dq[$];
  cpu_exp_t  cq[$];

  dsp_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  dsp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_dout = ram_q;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    disp_exp_t de;
    cpu_exp_t  ce;
    if (!reset) begin
      if (bus.disp_valid) begin
        check_val("disp_pending", 32'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
          de = dq.pop_front();
          check_val("disp_data", 32'(bus.disp_data), 32'(de.data));
          check_val("disp_latency", cyc, de.due);
        end
      end
      if (bus.cpu_ack) begin
        check_val("cpu_pending", 32'(cq.size() > 0), 1);
        if (cq.size() > 0) begin
          ce = cq.pop_front();
          if (!ce.we) check_val("cpu_dout", 32'(bus.cpu_dout), 32'(ce.data));
          if (ce.lat >= 0) check_val("cpu_latency", cyc - ce.start, ce.lat);
          else             check_val("cpu_latency_bound", 32'((cyc - ce.start) <= 3), 1);
        end
      end
    end
  end

  task automatic disp_issue(input logic [AW-1:0] addr);
    disp_exp_t e;
    e.data = ref_mem[addr];
    e.due  = cyc + 2;
    dq.push_back(e);
    bus.disp_req  = 1'b1;
    bus.disp_addr = addr;
    @(negedge clk);
    check_val("disp_issue_en", 32'(bus.mem_en), 1);
    check_val("disp_issue_we", 32'(bus.mem_we), 0);
    check_val("disp_issue_addr", 32'(bus.mem_addr), 32'(addr));
    tick();
    bus.disp_req = 1'b0;
  endtask

  // lat < 0 means only the worst-case bound is checked.
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] din, input int lat);
    cpu_exp_t e;
    int n;
    e.we    = we;
    e.data  = ref_mem[addr];
    e.start = cyc;
    e.lat   = lat;
    if (we) ref_mem[addr] = din;
    cq.push_back(e);
    bus.cpu_stb  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = addr;
    bus.cpu_din  = din;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ack && n < 20);
    check_val("cpu_ack_seen", 32'(bus.cpu_ack), 1);
    tick();
    bus.cpu_stb = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_end;
    int n;
    cpu_exp_t e;
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 16'(i * 37 + 16'h1000);
      ref_mem[i] = 16'(i * 37 + 16'h1000);
    end
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    reset = 1'b1;

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_disp_valid", 32'(bus.disp_valid), 0);
    check_val("rst_cpu_ack", 32'(bus.cpu_ack), 0);
    check_val("rst_disp_data", 32'(bus.disp_data), 0);
    check_val("rst_cpu_dout", 32'(bus.cpu_dout), 0);
    check_val("rst_mem_en", 32'(bus.mem_en), 0);
    tick();

    fork
      cpu_access(1'b1, 12'h123, 16'h4A07, 1);
      begin
        @(negedge clk);
        check_val("wr_grant_en", 32'(bus.mem_en), 1);
        check_val("wr_grant_we", 32'(bus.mem_we), 1);
        check_val("wr_grant_addr", 32'(bus.mem_addr), 32'h123);
        check_val("wr_grant_din", 32'(bus.mem_din), 32'h4A07);
      end
    join
    cpu_access(1'b0, 12'h123, '0, 2);
    cpu_access(1'b1, 12'hFFF, 16'hBEEF, 1);
    cpu_access(1'b0, 12'hFFF, '0, 2);

    // Collision: display wins, CPU read goes one cycle later.
    fork
      disp_issue(12'h050);
      cpu_access(1'b0, 12'h7FF, '0, 3);
      begin
        tick();
        @(negedge clk);
        check_val("cpu_deferred_en", 32'(bus.mem_en), 1);
        check_val("cpu_deferred_we", 32'(bus.mem_we), 0);
        check_val("cpu_deferred_addr", 32'(bus.mem_addr), 32'h7FF);
      end
    join
    repeat (3) tick();

    // CPU read in flight, display read issued the next cycle.
    fork
      cpu_access(1'b0, 12'h3C1, '0, 2);
      begin
        tick();
        disp_issue(12'h0A7);
      end
    join
    repeat (3) tick();

    fork
      begin
        for (int k = 0; k < 13; k++) begin
          disp_issue(AW'($urandom_range(0, 4095)));
          repeat (15) tick();
        end
      end
      begin
        t_end = cyc + 200;
        while (cyc < t_end) cpu_access(1'b0, AW'($urandom_range(0, 4095)), '0, -1);
      end
    join
    repeat (3) tick();

    // Reset during RD_WAIT abandons the read; stb stays high and it reissues.
    bus.cpu_stb = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h2A5;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_val("rst_rdwait_no_ack", 32'(bus.cpu_ack), 0);
    check_val("rst_rdwait_no_dvalid", 32'(bus.disp_valid), 0);
    tick();
    reset = 1'b0;
    e.we = 1'b0; e.data = ref_mem[12'h2A5]; e.start = cyc; e.lat = 2;
    cq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ack && n < 20);
    check_val("rst_reissue_ack", 32'(bus.cpu_ack), 1);
    tick();
    bus.cpu_stb = 1'b0;
    repeat (4) tick();

    check_val("disp_queue_empty", dq.size(), 0);
    check_val("cpu_queue_empty", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
